imem_dmem_port_arbiter: RTL

- Shares the single-port 1024x32 fetch block RAM between the instruction-fetch stage and the load/store unit.
- Arbitrates one access per cycle and drives the RAM's address/byteenable/chipselect/write/writedata/clken.
- Routes the RAM's one-cycle-latency read data back to the owning requester with a readdatavalid strobe.
- Data port has priority, bounded by an anti-starvation counter so fetch keeps making progress.

---
 rtl/imem_dmem_arb_pkg.sv | 7 +
 rtl/imem_dmem_port_arbiter.sv | 63 ++++++
 2 files changed

// File: rtl/imem_dmem_arb_pkg.sv
// imem_dmem_arb_pkg: shared types and defaults for the fetch/data RAM port arbiter
package imem_dmem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam int RD_LATENCY = 1;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter: shares one single-port RAM between fetch and load/store, data first with bounded streak
module imem_dmem_port_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_read,
  input  logic [ADDR_W-1:0]   if_address,
  input  logic                if_flush,
  output logic                if_waitrequest,
  output logic [DATA_W-1:0]   if_readdata,
  output logic                if_readdatavalid,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
  logic [SW-1:0] streak;
  owner_t owner;
  logic d_req, grant_d, grant_if;
  // fetch is forced through once data has won SMAX times in a row against a waiting fetch
  assign d_req = d_read | d_write;
  assign grant_d = ~reset & d_req & ~(if_read & (streak == SMAX));
  assign grant_if = ~reset & if_read & ~grant_d;
  assign if_waitrequest = if_read & ~grant_if;
  assign d_waitrequest = d_req & ~grant_d;
  assign mem_address = grant_d ? d_address : if_address;
  assign mem_byteenable = (grant_d & d_write) ? d_byteenable : '1;
  assign mem_chipselect = grant_d | grant_if;
  assign mem_write = grant_d & d_write;
  assign mem_writedata = d_writedata;
  assign mem_clken = ~reset;
  assign if_readdata = mem_readdata;
  assign d_readdata = mem_readdata;
  assign if_readdatavalid = ~reset & (owner == OWN_IF) & ~if_flush;
  assign d_readdatavalid = ~reset & (owner == OWN_D);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= OWN_NONE;
      streak <= '0;
    end else begin
      owner <= grant_d ? (d_read ? OWN_D : OWN_NONE) : grant_if ? OWN_IF : OWN_NONE;
      streak <= (grant_if | ~if_read) ? '0 : (grant_d && streak != SMAX) ? streak + SW'(1) : streak;
    end
  assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));
endmodule
